connect4_turn_controller: RTL and testbench

- Owns the authoritative Connect-Four board: CPU stones, human stones and per-column pile counts.
- Sequences one human move, then one CPU move per turn. For the CPU move it launches the game-tree search core (m_game_tree_v2 interface), collects the selected column, validates it and commits it.
- Sits between the button/input logic, the search core and the ST7789 draw logic.
- Board layout: bit index = row*7 + col, with row 0 at the bottom. Pile count for column c is at bits [3c+2:3c].

---
 rtl/connect4_turn_controller.sv | 187 ++++++++++++++++++
 tb/tb_connect4_turn_controller.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/connect4_turn_controller.sv
// connect4_turn_controller: owns the Connect-Four board and sequences human/CPU turns around the search core.
module connect4_turn_controller #(
  parameter bit          CPU_FIRST = 1'b0,
  parameter logic [23:0] TIMEOUT   = 24'd10_000_000
) (
  input  logic        w_clk,
  input  logic        w_rst_n,
  input  logic        i_move_valid,
  input  logic [2:0]  i_move_col,
  input  logic        i_new_game,
  output logic        o_gt_rst,
  output logic        o_gt_en,
  input  logic        i_gt_valid,
  input  logic        i_gt_finished,
  input  logic [2:0]  i_gt_col,
  input  logic [15:0] i_gt_score,
  output logic [41:0] o_me_field,
  output logic [41:0] o_op_field,
  output logic [20:0] o_piled_array,
  output logic [2:0]  o_state,
  output logic        o_human_turn,
  output logic [2:0]  o_last_col,
  output logic [15:0] o_last_score,
  output logic [5:0]  o_move_cnt,
  output logic        o_illegal,
  output logic        o_fallback,
  output logic        o_redraw,
  output logic        o_game_over
);
  typedef enum logic [2:0] {
    WAIT_HUMAN = 3'd0,
    CHECK_H    = 3'd1,
    START_GT   = 3'd2,
    WAIT_GT    = 3'd3,
    APPLY_ME   = 3'd4,
    CHECK_M    = 3'd5,
    OVER       = 3'd6
  } state_t;
  localparam state_t INIT = CPU_FIRST ? START_GT : WAIT_HUMAN;
  state_t      state_q, state_d;
  logic [41:0] me_q, me_d, op_q, op_d;
  logic [20:0] pile_q, pile_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [2:0]  last_col_q, last_col_d, gt_col_q, gt_col_d;
  logic [15:0] last_score_q, last_score_d;
  logic [23:0] tmo_q, tmo_d;
  logic        illegal_q, illegal_d, fallback_q, fallback_d, redraw_q, redraw_d;
  logic        gt_rst_q, gt_rst_d, gt_en_q, gt_en_d, human_q, human_d, over_q, over_d;
  logic [2:0]  pile [8];
  logic [2:0]  left_col, ap_col, mv_col;
  logic        gt_legal, mv_legal;
  logic [5:0]  mv_bit;
  logic [20:0] mv_inc;
  // Entry 7 reads as a full column so an out-of-range column is simply illegal.
  always_comb begin
    for (int i = 0; i < 7; i++) pile[i] = pile_q[3*i +: 3];
    pile[7] = 3'd6;
    left_col = 3'd0;
    for (int i = 6; i >= 0; i--) if (pile[i] < 3'd6) left_col = 3'(i);
  end
  assign gt_legal = pile[gt_col_q] < 3'd6;
  assign ap_col   = gt_legal ? gt_col_q : left_col;
  assign mv_col   = (state_q == APPLY_ME) ? ap_col : i_move_col;
  assign mv_legal = pile[mv_col] < 3'd6;
  assign mv_bit   = {3'b0, pile[mv_col]} * 6'd7 + {3'b0, mv_col};
  assign mv_inc   = 21'd1 << ({2'b0, mv_col} * 5'd3);
  always_comb begin
    state_d      = state_q;
    me_d         = me_q;
    op_d         = op_q;
    pile_d       = pile_q;
    cnt_d        = cnt_q;
    last_col_d   = last_col_q;
    last_score_d = last_score_q;
    gt_col_d     = gt_col_q;
    tmo_d        = tmo_q;
    illegal_d    = 1'b0;
    fallback_d   = 1'b0;
    redraw_d     = 1'b0;
    if (i_new_game) begin
      state_d      = INIT;
      me_d         = '0;
      op_d         = '0;
      pile_d       = '0;
      cnt_d        = '0;
      last_col_d   = '0;
      last_score_d = '0;
      tmo_d        = '0;
    end else begin
      case (state_q)
        WAIT_HUMAN: if (i_move_valid) begin
          if (mv_legal) begin
            op_d[mv_bit] = 1'b1;
            pile_d       = pile_q + mv_inc;
            cnt_d        = cnt_q + 6'd1;
            last_col_d   = mv_col;
            redraw_d     = 1'b1;
            state_d      = CHECK_H;
          end else illegal_d = 1'b1;
        end
        CHECK_H: state_d = (cnt_q == 6'd42) ? OVER : START_GT;
        START_GT: begin
          tmo_d   = '0;
          state_d = WAIT_GT;
        end
        WAIT_GT: begin
          tmo_d = tmo_q + 24'd1;
          if (i_gt_valid && i_gt_finished) begin
            gt_col_d     = i_gt_col;
            last_score_d = i_gt_score;
            state_d      = APPLY_ME;
          end else if (tmo_q == TIMEOUT - 24'd1) begin
            gt_col_d = 3'd7;
            state_d  = APPLY_ME;
          end
        end
        APPLY_ME: begin
          me_d[mv_bit] = 1'b1;
          pile_d       = pile_q + mv_inc;
          cnt_d        = cnt_q + 6'd1;
          last_col_d   = mv_col;
          fallback_d   = !gt_legal;
          redraw_d     = 1'b1;
          state_d      = CHECK_M;
        end
        CHECK_M: state_d = (cnt_q == 6'd42) ? OVER : WAIT_HUMAN;
        OVER:    state_d = OVER;
        default: state_d = INIT;
      endcase
    end
    gt_rst_d = state_d != WAIT_GT;
    gt_en_d  = state_d == WAIT_GT;
    human_d  = state_d == WAIT_HUMAN;
    over_d   = state_d == OVER;
  end
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_q      <= INIT;
      me_q         <= '0;
      op_q         <= '0;
      pile_q       <= '0;
      cnt_q        <= '0;
      last_col_q   <= '0;
      last_score_q <= '0;
      gt_col_q     <= '0;
      tmo_q        <= '0;
      illegal_q    <= 1'b0;
      fallback_q   <= 1'b0;
      redraw_q     <= 1'b0;
      gt_rst_q     <= 1'b1;
      gt_en_q      <= 1'b0;
      human_q      <= INIT == WAIT_HUMAN;
      over_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      me_q         <= me_d;
      op_q         <= op_d;
      pile_q       <= pile_d;
      cnt_q        <= cnt_d;
      last_col_q   <= last_col_d;
      last_score_q <= last_score_d;
      gt_col_q     <= gt_col_d;
      tmo_q        <= tmo_d;
      illegal_q    <= illegal_d;
      fallback_q   <= fallback_d;
      redraw_q     <= redraw_d;
      gt_rst_q     <= gt_rst_d;
      gt_en_q      <= gt_en_d;
      human_q      <= human_d;
      over_q       <= over_d;
    end
  end
  assign o_gt_rst      = gt_rst_q;
  assign o_gt_en       = gt_en_q;
  assign o_me_field    = me_q;
  assign o_op_field    = op_q;
  assign o_piled_array = pile_q;
  assign o_state       = state_q;
  assign o_human_turn  = human_q;
  assign o_last_col    = last_col_q;
  assign o_last_score  = last_score_q;
  assign o_move_cnt    = cnt_q;
  assign o_illegal     = illegal_q;
  assign o_fallback    = fallback_q;
  assign o_redraw      = redraw_q;
  assign o_game_over   = over_q;
endmodule

// File: tb/tb_connect4_turn_controller.sv
// tb_connect4_turn_controller: directed checks of turn sequencing, legality, fallback, timeout and reset.
module tb_connect4_turn_controller;
  logic        clk = 1'b0, rst_n = 1'b0, rst2_n = 1'b0;
  logic        mv_valid = 1'b0, new_game = 1'b0, gt_valid = 1'b0, gt_fin = 1'b0;
  logic [2:0]  mv_col = 3'd0, gt_col = 3'd0;
  logic [15:0] gt_score = 16'd0;
  logic        gt_rst, gt_en, human, illegal, fallback, redraw, over;
  logic [41:0] me, op;
  logic [20:0] pile;
  logic [2:0]  state, last_col;
  logic [15:0] last_score;
  logic [5:0]  cnt;
  logic        d2_gt_rst, d2_gt_en, d2_human, d2_illegal, d2_fallback, d2_redraw, d2_over;
  logic [41:0] d2_me, d2_op;
  logic [20:0] d2_pile;
  logic [2:0]  d2_state, d2_last_col;
  logic [15:0] d2_last_score;
  logic [5:0]  d2_cnt;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  connect4_turn_controller #(.CPU_FIRST(1'b0), .TIMEOUT(24'd100)) dut (
    .w_clk(clk), .w_rst_n(rst_n), .i_move_valid(mv_valid), .i_move_col(mv_col), .i_new_game(new_game),
    .o_gt_rst(gt_rst), .o_gt_en(gt_en), .i_gt_valid(gt_valid), .i_gt_finished(gt_fin), .i_gt_col(gt_col),
    .i_gt_score(gt_score), .o_me_field(me), .o_op_field(op), .o_piled_array(pile), .o_state(state),
    .o_human_turn(human), .o_last_col(last_col), .o_last_score(last_score), .o_move_cnt(cnt),
    .o_illegal(illegal), .o_fallback(fallback), .o_redraw(redraw), .o_game_over(over));
  connect4_turn_controller #(.CPU_FIRST(1'b1), .TIMEOUT(24'd100)) dut2 (
    .w_clk(clk), .w_rst_n(rst2_n), .i_move_valid(1'b0), .i_move_col(3'd0), .i_new_game(1'b0),
    .o_gt_rst(d2_gt_rst), .o_gt_en(d2_gt_en), .i_gt_valid(1'b0), .i_gt_finished(1'b0), .i_gt_col(3'd0),
    .i_gt_score(16'd0), .o_me_field(d2_me), .o_op_field(d2_op), .o_piled_array(d2_pile), .o_state(d2_state),
    .o_human_turn(d2_human), .o_last_col(d2_last_col), .o_last_score(d2_last_score), .o_move_cnt(d2_cnt),
    .o_illegal(d2_illegal), .o_fallback(d2_fallback), .o_redraw(d2_redraw), .o_game_over(d2_over));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic human_move(input logic [2:0] c);
    mv_valid = 1'b1;
    mv_col = c;
    tick;
    mv_valid = 1'b0;
  endtask
  task automatic cpu_move(input logic [2:0] c, input logic [15:0] s);
    for (int n = 0; n < 300 && !gt_en; n++) tick;
    tests++; if (gt_en !== 1'b1) begin fails++; $display("FAIL cpu_wait_en: got %b want 1", gt_en); end
    gt_valid = 1'b1; gt_fin = 1'b1; gt_col = c; gt_score = s;
    tick;
    gt_valid = 1'b0; gt_fin = 1'b0;
    tick;
    tick;
  endtask
  task automatic test_reset;
    tick;
    tests++; if (state !== 3'd0) begin fails++; $display("FAIL rst_state: got %0d want 0", state); end
    tests++; if ({gt_rst, gt_en, human} !== 3'b101) begin fails++; $display("FAIL rst_gt_human: got %b want 101", {gt_rst, gt_en, human}); end
    tests++; if ({me, op, pile, cnt} !== '0) begin fails++; $display("FAIL rst_board: me=%h op=%h pile=%h cnt=%0d want 0", me, op, pile, cnt); end
    tests++; if ({illegal, fallback, redraw, over, last_col, last_score} !== '0) begin fails++; $display("FAIL rst_pulses: got %b want 0", {illegal, fallback, redraw, over}); end
    rst_n = 1'b1;
    tick;
  endtask
  task automatic test_first_turn;
    human_move(3'd3);
    tests++; if (op !== 42'h8 || pile !== 21'h200 || cnt !== 6'd1) begin fails++; $display("FAIL h3_commit: op=%h pile=%h cnt=%0d want 8/200/1", op, pile, cnt); end
    tests++; if (redraw !== 1'b1 || state !== 3'd1 || last_col !== 3'd3) begin fails++; $display("FAIL h3_redraw: redraw=%b state=%0d col=%0d want 1/1/3", redraw, state, last_col); end
    tick;
    tests++; if (state !== 3'd2 || gt_rst !== 1'b1 || gt_en !== 1'b0 || redraw !== 1'b0) begin fails++; $display("FAIL start_gt: state=%0d rst=%b en=%b redraw=%b", state, gt_rst, gt_en, redraw); end
    tick;
    tests++; if (state !== 3'd3 || gt_rst !== 1'b0 || gt_en !== 1'b1) begin fails++; $display("FAIL wait_gt: state=%0d rst=%b en=%b want 3/0/1", state, gt_rst, gt_en); end
    for (int i = 0; i < 19; i++) tick;
    gt_valid = 1'b1; gt_fin = 1'b1; gt_col = 3'd3; gt_score = 16'h1234;
    tick;
    gt_valid = 1'b0; gt_fin = 1'b0;
    tests++; if (state !== 3'd4 || gt_rst !== 1'b1 || last_score !== 16'h1234) begin fails++; $display("FAIL apply_me: state=%0d rst=%b score=%h", state, gt_rst, last_score); end
    tick;
    tests++; if (me !== 42'h400 || pile !== 21'h400 || cnt !== 6'd2 || redraw !== 1'b1 || fallback !== 1'b0) begin fails++; $display("FAIL cpu_commit: me=%h pile=%h cnt=%0d redraw=%b fb=%b", me, pile, cnt, redraw, fallback); end
    tick;
    tests++; if (state !== 3'd0 || human !== 1'b1) begin fails++; $display("FAIL back_human: state=%0d human=%b want 0/1", state, human); end
  endtask
  task automatic test_illegal;
    for (int i = 0; i < 3; i++) begin
      human_move(3'd0);
      cpu_move(3'd0, 16'h0010);
    end
    tests++; if (op !== 42'h10004009 || me !== 42'h800200480) begin fails++; $display("FAIL col0_fill: op=%h me=%h want 10004009/800200480", op, me); end
    tests++; if (pile !== 21'h406 || cnt !== 6'd8) begin fails++; $display("FAIL col0_pile: pile=%h cnt=%0d want 406/8", pile, cnt); end
    human_move(3'd0);
    tests++; if (illegal !== 1'b1 || state !== 3'd0 || redraw !== 1'b0) begin fails++; $display("FAIL ill_full: ill=%b state=%0d redraw=%b want 1/0/0", illegal, state, redraw); end
    tests++; if (op !== 42'h10004009 || pile !== 21'h406 || cnt !== 6'd8) begin fails++; $display("FAIL ill_board: op=%h pile=%h cnt=%0d", op, pile, cnt); end
    tick;
    tests++; if (illegal !== 1'b0) begin fails++; $display("FAIL ill_pulse_len: got %b want 0", illegal); end
    human_move(3'd7);
    tests++; if (illegal !== 1'b1 || state !== 3'd0 || cnt !== 6'd8) begin fails++; $display("FAIL ill_col7: ill=%b state=%0d cnt=%0d", illegal, state, cnt); end
    tick;
  endtask
  task automatic test_fallback;
    human_move(3'd2);
    for (int n = 0; n < 300 && !gt_en; n++) tick;
    gt_valid = 1'b1; gt_fin = 1'b1; gt_col = 3'd0; gt_score = 16'h00AB;
    tick;
    gt_valid = 1'b0; gt_fin = 1'b0;
    tick;
    tests++; if (fallback !== 1'b1 || last_col !== 3'd1) begin fails++; $display("FAIL fb_pulse: fb=%b col=%0d want 1/1", fallback, last_col); end
    tests++; if (me !== 42'h800200482 || pile !== 21'h44E || cnt !== 6'd10) begin fails++; $display("FAIL fb_board: me=%h pile=%h cnt=%0d", me, pile, cnt); end
    tick;
    tick;
  endtask
  task automatic test_timeout;
    int n;
    human_move(3'd4);
    for (int k = 0; k < 300 && state != 3'd3; k++) tick;
    n = 0;
    while (state == 3'd3 && n < 1000) begin tick; n++; end
    tests++; if (n !== 100 || state !== 3'd4) begin fails++; $display("FAIL tmo_cycles: got %0d in state %0d want 100 then 4", n, state); end
    tick;
    tests++; if (fallback !== 1'b1 || me !== 42'h800200582 || last_col !== 3'd1) begin fails++; $display("FAIL tmo_commit: fb=%b me=%h col=%0d", fallback, me, last_col); end
    tests++; if (last_score !== 16'h00AB || cnt !== 6'd12) begin fails++; $display("FAIL tmo_score: score=%h cnt=%0d want 00ab/12", last_score, cnt); end
    tick;
    tick;
  endtask
  task automatic test_full_board;
    new_game = 1'b1;
    tick;
    new_game = 1'b0;
    tests++; if ({me, op, pile, cnt} !== '0 || state !== 3'd0) begin fails++; $display("FAIL ng_clear: me=%h op=%h cnt=%0d state=%0d", me, op, cnt, state); end
    for (int c = 0; c < 7; c++)
      for (int r = 0; r < 3; r++) begin
        human_move(3'(c));
        cpu_move(3'(c), 16'(c));
      end
    tests++; if (state !== 3'd6 || over !== 1'b1 || human !== 1'b0 || cnt !== 6'd42) begin fails++; $display("FAIL full_over: state=%0d over=%b human=%b cnt=%0d", state, over, human, cnt); end
    tests++; if (op !== 42'h7F01FC07F || me !== 42'h3F80FE03F80 || pile !== 21'o6666666) begin fails++; $display("FAIL full_board: op=%h me=%h pile=%o", op, me, pile); end
    human_move(3'd3);
    tests++; if (state !== 3'd6 || illegal !== 1'b0 || cnt !== 6'd42) begin fails++; $display("FAIL over_ignore: state=%0d ill=%b cnt=%0d", state, illegal, cnt); end
    new_game = 1'b1; mv_valid = 1'b1; mv_col = 3'd2;
    tick;
    new_game = 1'b0; mv_valid = 1'b0;
    tests++; if ({me, op, cnt} !== '0 || state !== 3'd0 || over !== 1'b0 || human !== 1'b1) begin fails++; $display("FAIL ng_after_over: cnt=%0d state=%0d over=%b op=%h", cnt, state, over, op); end
  endtask
  task automatic test_async_reset;
    human_move(3'd5);
    for (int k = 0; k < 300 && !gt_en; k++) tick;
    for (int k = 0; k < 5; k++) tick;
    #2 rst_n = 1'b0;
    #1;
    tests++; if (state !== 3'd0 || gt_rst !== 1'b1 || gt_en !== 1'b0 || human !== 1'b1) begin fails++; $display("FAIL arst_ctrl: state=%0d rst=%b en=%b human=%b", state, gt_rst, gt_en, human); end
    tests++; if ({op, me, pile, cnt, last_col} !== '0) begin fails++; $display("FAIL arst_board: op=%h cnt=%0d col=%0d", op, cnt, last_col); end
    rst_n = 1'b1;
    tick;
  endtask
  task automatic test_cpu_first;
    int n;
    tests++; if (d2_state !== 3'd2 || d2_gt_rst !== 1'b1 || d2_gt_en !== 1'b0 || d2_human !== 1'b0) begin fails++; $display("FAIL cf_reset: state=%0d rst=%b en=%b human=%b", d2_state, d2_gt_rst, d2_gt_en, d2_human); end
    rst2_n = 1'b1;
    tick;
    tests++; if (d2_state !== 3'd3 || d2_gt_en !== 1'b1 || {d2_me, d2_op, d2_pile} !== '0) begin fails++; $display("FAIL cf_search: state=%0d en=%b me=%h op=%h", d2_state, d2_gt_en, d2_me, d2_op); end
    n = 0;
    while (d2_state == 3'd3 && n < 1000) begin tick; n++; end
    tick;
    tests++; if (n !== 100 || d2_me !== 42'h1 || d2_fallback !== 1'b1 || d2_cnt !== 6'd1) begin fails++; $display("FAIL cf_fallback: n=%0d me=%h fb=%b cnt=%0d", n, d2_me, d2_fallback, d2_cnt); end
  endtask
  initial begin
    test_reset;
    test_first_turn;
    test_illegal;
    test_fallback;
    test_timeout;
    test_full_board;
    test_async_reset;
    test_cpu_first;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
